// File: rtl/inst_mem_pkg.sv
// rtl/inst_mem_pkg.sv - shared types, defaults and parity helper for the loadable instruction memory
package inst_mem_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    LOAD = 1'b1
  } state_t;

  localparam int DEF_IW = 9;
  localparam int DEF_AW = 11;
  localparam logic [DEF_IW-1:0] DEF_HALT_WORD = {DEF_IW{1'b1}};

  // Even parity over a zero-extended word; callers cast their data to 64 bits.
  function automatic logic even_parity(input logic [63:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/inst_mem_loadable_if.sv
// rtl/inst_mem_loadable_if.sv - load stream and fetch port bundle for inst_mem_loadable
interface inst_mem_loadable_if #(
  parameter int IW = inst_mem_pkg::DEF_IW,
  parameter int AW = inst_mem_pkg::DEF_AW
);

  logic          load_start;
  logic          load_valid;
  logic [IW-1:0] load_data;
  logic          load_last;
  logic          load_ready;
  logic          loading;
  logic          load_full;
  logic [AW:0]   prog_len;

  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic [IW-1:0] inst_out;
  logic          inst_valid;
  logic          out_of_range;
  logic          parity_err;

  modport master (
    output load_start, load_valid, load_data, load_last, fetch_req, fetch_addr,
    input  load_ready, loading, load_full, prog_len,
    input  inst_out, inst_valid, out_of_range, parity_err
  );

  modport slave (
    input  load_start, load_valid, load_data, load_last, fetch_req, fetch_addr,
    output load_ready, loading, load_full, prog_len,
    output inst_out, inst_valid, out_of_range, parity_err
  );

endinterface

// File: rtl/inst_mem_array.sv
// rtl/inst_mem_array.sv - single-port synchronous RAM with registered, read-enabled output
module inst_mem_array #(
  parameter int WIDTH  = 9,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  din,
  output logic [WIDTH-1:0]  dout
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0] mem [DEPTH];

  // Array contents survive reset; only the output register is cleared.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= '0;
    end else if (re) begin
      dout <= mem[addr];
    end
  end

endmodule

// File: rtl/inst_mem_loadable.sv
// rtl/inst_mem_loadable.sv - runtime-loadable instruction memory; optional INST_MEM_PARITY_EN adds stored parity
module inst_mem_loadable
  import inst_mem_pkg::*;
#(
  parameter int            IW        = DEF_IW,
  parameter int            AW        = DEF_AW,
  parameter logic [IW-1:0] HALT_WORD = {IW{1'b1}}
) (
  input  logic                 Clk,
  input  logic                 Reset,
  inst_mem_loadable_if.slave   bus
);

`ifdef INST_MEM_PARITY_EN
  localparam int MW = IW + 1;
`else
  localparam int MW = IW;
`endif

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q;
  logic [AW:0]   prog_len_q;
  logic          load_full_q;
  logic          inst_valid_q;
  logic          oor_q;

  logic          accept;
  logic          done;
  logic          full_stop;
  logic          fetch_ok;
  logic          in_range;
  logic [MW-1:0] wr_word;
  logic [MW-1:0] rd_word;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    done      = 1'b0;
    full_stop = 1'b0;
    fetch_ok  = 1'b0;
    case (state_q)
      RUN: begin
        fetch_ok = bus.fetch_req;
        if (bus.load_start) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        accept = bus.load_valid;
        // Running off the top of the array ends the load just like load_last.
        if (accept && (bus.load_last || (&wr_ptr_q))) begin
          done      = 1'b1;
          full_stop = !bus.load_last;
          state_d   = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  assign in_range = ({1'b0, bus.fetch_addr} < prog_len_q);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr_q     <= '0;
      prog_len_q   <= '0;
      load_full_q  <= 1'b0;
      inst_valid_q <= 1'b0;
      oor_q        <= 1'b0;
    end else begin
      inst_valid_q <= fetch_ok;
      if (fetch_ok) begin
        oor_q <= !in_range;
      end
      if ((state_q == RUN) && bus.load_start) begin
        wr_ptr_q    <= '0;
        load_full_q <= 1'b0;
      end
      if (accept) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (done) begin
        prog_len_q <= {1'b0, wr_ptr_q} + (AW+1)'(1);
      end
      if (full_stop) begin
        load_full_q <= 1'b1;
      end
    end
  end

`ifdef INST_MEM_PARITY_EN
  assign wr_word        = {even_parity(64'(bus.load_data)), bus.load_data};
  assign bus.parity_err = inst_valid_q && !oor_q &&
                          (even_parity(64'(rd_word[IW-1:0])) != rd_word[IW]);
`else
  assign wr_word        = bus.load_data;
  assign bus.parity_err = 1'b0;
`endif

  // Reads and writes never overlap: writes only in LOAD, reads only in RUN.
  inst_mem_array #(
    .WIDTH  (MW),
    .ADDR_W (AW)
  ) u_array (
    .clk  (Clk),
    .rst  (Reset),
    .we   (accept),
    .re   (fetch_ok && in_range),
    .addr ((state_q == LOAD) ? wr_ptr_q : bus.fetch_addr),
    .din  (wr_word),
    .dout (rd_word)
  );

  assign bus.load_ready   = (state_q == LOAD);
  assign bus.loading      = (state_q == LOAD);
  assign bus.load_full    = load_full_q;
  assign bus.prog_len     = prog_len_q;
  assign bus.inst_valid   = inst_valid_q;
  assign bus.out_of_range = inst_valid_q && oor_q;
  assign bus.inst_out     = oor_q ? HALT_WORD : rd_word[IW-1:0];

endmodule

// File: doc/inst_mem_loadable.md
Name: inst_mem_loadable

Overview:
- Parametrised, runtime-loadable instruction memory for the CSE141L-style core. Replaces the file-initialised, combinational-read instruction ROM.
- Program words are streamed in through a valid/ready load port driven by a testbench or host loader.
- The fetch stage reads one word per cycle through a registered request/valid port with one-cycle latency.
- Fetches beyond the loaded program length return a HALT word, so the core stops cleanly instead of executing garbage.

Parameters:
- IW, 9, instruction word width in bits
- AW, 11, address width; DEPTH = 2**AW words
- HALT_WORD, {IW{1'b1}}, word returned for out-of-range fetches

Ports:
- Clk  input  1  system clock; all state updates on rising edge
- Reset  input  1  synchronous, active-high reset
- load_start  input  1  pulse: begin a new program load
- load_valid  input  1  load_data is valid this cycle
- load_data  input  IW  program word to write
- load_last  input  1  qualifies load_valid: final word of the program
- load_ready  output  1  memory accepts a load word this cycle
- loading  output  1  high while in LOAD state
- load_full  output  1  sticky: last load hit DEPTH without load_last
- prog_len  output  AW+1  number of valid words loaded (0..DEPTH)
- fetch_req  input  1  fetch request this cycle
- fetch_addr  input  AW  word address to fetch
- inst_out  output  IW  fetched instruction (registered)
- inst_valid  output  1  inst_out is new this cycle
- out_of_range  output  1  with inst_valid: the address was >= prog_len
- parity_err  output  1  with inst_valid: stored parity mismatch (see optional feature)

Behaviour:
- Clock and reset: single clock Clk; reset is synchronous, active-high (Reset). Memory array contents are not cleared by reset.
- Reset values: state=RUN, wr_ptr=0, prog_len=0, load_full=0, inst_out=0, inst_valid=0, out_of_range=0, parity_err=0, load_ready=0, loading=0.
- FSM states: RUN, LOAD.
  - RUN -> LOAD on load_start. In that cycle, wr_ptr<=0 and load_full<=0.
  - LOAD -> RUN on an accepted word with load_last=1. prog_len<=wr_ptr+1.
  - LOAD -> RUN on an accepted word with wr_ptr==DEPTH-1 and load_last=0. prog_len<=DEPTH and load_full<=1.
  - load_start while in LOAD is ignored.
- load_ready = (state==LOAD). A word is accepted when load_valid && load_ready: mem[wr_ptr]<=load_data, then wr_ptr++. load_valid with load_ready low is dropped with no write.
- During LOAD, prog_len keeps its previous value until completion.
- Fetch:
  - Served only in RUN. fetch_req in cycle N produces inst_valid=1 in cycle N+1, with inst_out valid in the same cycle.
  - With no request, inst_valid=0 and inst_out holds its last value.
  - fetch_req in LOAD is ignored (inst_valid=0 next cycle).
  - A fetch accepted in the same cycle as load_start (still in RUN) is served normally.
- Range check: fetch_addr >= prog_len gives inst_out=HALT_WORD and out_of_range=1. Otherwise inst_out=mem[fetch_addr] and out_of_range=0. Use an AW+1-bit compare, with no wrap.
- Write/read collision: none is possible, because reads and writes occur in mutually exclusive states.
- Reset during LOAD: returns to RUN with prog_len=0. All subsequent fetches return HALT_WORD with out_of_range=1.
- Single-word program (first accepted word carries load_last): prog_len=1.

Optional Feature:
- INST_MEM_PARITY_EN defined:
  - Each stored word is IW+1 bits, with an even-parity bit computed on write.
  - The fetch path recomputes parity. parity_err=1 with inst_valid on mismatch.
  - parity_err is forced 0 on out-of-range fetches.
  - A bench-only hierarchical force on the stored parity bit is the supported fault-injection method.
- Not defined: the array is IW bits wide and parity_err is tied to 0. The port list is identical in both builds.

Decomposition:
- Shared package inst_mem_pkg holds:
  - state enum (RUN, LOAD)
  - default IW/AW constants
  - HALT_WORD default
  - parity function
- One sub-module, inst_mem_array: a single-port synchronous RAM (write enable, address, data in, registered data out), parametrised by width and depth.
- The FSM, pointers, range check and parity logic stay in the top level.

Test Plan:
- Reset, then fetch_req with addr=0 -> next cycle inst_valid=1, inst_out=9'h1FF, out_of_range=1, prog_len=0.
- load_start, then stream 5 words 9'h001..9'h005 (last on the 5th) -> loading drops, prog_len=5. Fetch addr 0..4 returns 001..005 one cycle later; addr 5 returns 1FF with out_of_range=1.
- Load with load_valid gaps and load_valid asserted while in RUN -> only words accepted in LOAD are stored, and wr_ptr has no holes.
- AW=3: stream 10 words with no load_last -> after 8 words state=RUN, prog_len=8, load_full=1. Words 9-10 are ignored with load_ready=0.
- Reset asserted mid-load after 3 words -> next cycle state=RUN, prog_len=0, all fetches return HALT. fetch_req during LOAD gives inst_valid=0.
- INST_MEM_PARITY_EN: load 9'h003, force its parity bit flipped, fetch addr 0 -> inst_valid=1, parity_err=1. An unforced word gives parity_err=0.
